// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Used by serial_subtractor_if, serial_subtractor and full_subtractor.
package serial_sub_pkg;

  localparam int SUB_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_w(input int w);
    int c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int W = SUB_W_DEF
);

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  modport master (
    output start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output busy, done, diff, borrow
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout set when a borrow is needed.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Pure combinational difference and borrow-out.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (A - B mod 2^W), LSB first, one bit per clock.
// Optional feature macro: SERIAL_SUB_OVF_EN (adds signed overflow output ovf).
//
// state | meaning
// IDLE  | waiting for start; diff/borrow hold the last result
// RUN   | one operand bit processed per clock, W clocks total
// DONE  | result valid, done pulsed for this single cycle
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int W = SUB_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  sub_state_e    state;
  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic [W-1:0]  sr;
  logic [W-1:0]  sr_nxt;
  logic [W-1:0]  diff_q;
  logic [CW-1:0] cnt;
  logic          bff;
  logic          busy_q;
  logic          done_q;
  logic          borrow_q;
  logic          d_bit;
  logic          bout_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic          sign_a;
  logic          sign_b;
  logic          ovf_q;
`endif

  full_subtractor u_fs (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (bff),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // Result shift register with this cycle's difference bit entering at the MSB.
  always_comb begin
    sr_nxt = '0;
    for (int i = 0; i < W - 1; i++) begin
      sr_nxt[i] = sr[i + 1];
    end
    sr_nxt[W-1] = d_bit;
  end

  // Control FSM and datapath registers; outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      cnt      <= '0;
      bff      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            sa     <= bus.a;
            sb     <= bus.b;
            bff    <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            sign_a <= bus.a[W-1];
            sign_b <= bus.b[W-1];
`endif
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= sr_nxt;
          bff <= bout_bit;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state    <= DONE;
            done_q   <= 1'b1;
            diff_q   <= sr_nxt;
            borrow_q <= bout_bit;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= (sign_a != sign_b) && (sr_nxt[W-1] != sign_a);
`endif
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: a W=8 and a W=1 instance.
// ovf is checked only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_diff;
    logic       exp_borrow;
    logic       exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.W(8)) bus8 ();
  serial_subtractor_if #(.W(1)) bus1 ();

  serial_subtractor #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse start for one accepting edge, then wait for done.
  // lat counts negedges after the accepting edge; nbusy counts busy samples.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat,
                      output int nbusy, output logic post_busy, output logic post_done);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = a;
    bus8.b = b;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = 0;
    nbusy = 0;
    while (bus8.done !== 1'b1 && lat < 40) begin
      if (bus8.busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (bus8.busy === 1'b1) nbusy++;
    @(negedge clk);
    post_busy = bus8.busy;
    post_done = bus8.done;
  endtask

  task automatic run1(input logic a, input logic b, output int lat);
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.a = a;
    bus1.b = b;
    @(negedge clk);
    bus1.start = 1'b0;
    lat = 0;
    while (bus1.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   lat;
    int   nbusy;
    int   first_done;
    int   second_done;
    int   ndone;
    logic pb;
    logic pd;
    logic busy_gap;
    logic [7:0] d_first;
    logic [7:0] d_second;
    logic [7:0] d_mid;
    logic b_first;
    logic b_second;
    logic ovf_second;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
    vecs[6] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
    vecs[7] = '{8'hC8, 8'h64, 8'h64, 1'b0, 1'b1};

    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus1.start = 1'b0;
    bus1.a = '0;
    bus1.b = '0;

    // Reset state
    #12;
    chk("rst_busy", 32'(bus8.busy), 32'h0);
    chk("rst_done", 32'(bus8.done), 32'h0);
    chk("rst_diff", 32'(bus8.diff), 32'h0);
    chk("rst_borrow", 32'(bus8.borrow), 32'h0);
    chk("rst_busy_w1", 32'(bus1.busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single operations
    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].a, vecs[i].b, lat, nbusy, pb, pd);
      n_vec++;
      chk($sformatf("v%0d_diff", i), 32'(bus8.diff), 32'(vecs[i].exp_diff));
      chk($sformatf("v%0d_borrow", i), 32'(bus8.borrow), 32'(vecs[i].exp_borrow));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd8);
      chk($sformatf("v%0d_busy_cycles", i), 32'(nbusy), 32'd9);
      chk($sformatf("v%0d_busy_after", i), 32'(pb), 32'h0);
      chk($sformatf("v%0d_done_after", i), 32'(pd), 32'h0);
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("v%0d_ovf", i), 32'(bus8.ovf), 32'(vecs[i].exp_ovf));
`endif
    end

    // Back-to-back with start held high: second accept at edge W+2
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = 8'hFF;
    bus8.b = 8'hFF;
    @(negedge clk);
    bus8.a = 8'h80;
    bus8.b = 8'h01;
    first_done = -1;
    second_done = -1;
    busy_gap = 1'bx;
    d_first = 'x;
    d_second = 'x;
    d_mid = 'x;
    b_first = 1'bx;
    b_second = 1'bx;
    ovf_second = 1'bx;
    for (int k = 0; k < 30; k++) begin
      if (bus8.done === 1'b1) begin
        if (first_done < 0) begin
          first_done = k;
          d_first = bus8.diff;
          b_first = bus8.borrow;
        end else if (second_done < 0) begin
          second_done = k;
          d_second = bus8.diff;
          b_second = bus8.borrow;
`ifdef SERIAL_SUB_OVF_EN
          ovf_second = bus8.ovf;
`endif
        end
      end
      if (k == 9) busy_gap = bus8.busy;
      if (k == 10) bus8.start = 1'b0;
      if (k == 14) d_mid = bus8.diff;
      @(negedge clk);
    end
    n_vec += 2;
    chk("b2b_first_done", 32'(first_done), 32'd8);
    chk("b2b_first_diff", 32'(d_first), 32'h00);
    chk("b2b_first_borrow", 32'(b_first), 32'h0);
    chk("b2b_idle_gap_busy", 32'(busy_gap), 32'h0);
    chk("b2b_diff_hold_in_run", 32'(d_mid), 32'h00);
    chk("b2b_second_done", 32'(second_done), 32'd18);
    chk("b2b_second_diff", 32'(d_second), 32'h7F);
    chk("b2b_second_borrow", 32'(b_second), 32'h0);
`ifdef SERIAL_SUB_OVF_EN
    chk("b2b_second_ovf", 32'(ovf_second), 32'h1);
`endif

    // start during RUN is ignored
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = 8'h10;
    bus8.b = 8'h01;
    @(negedge clk);
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      if (k == 0) bus8.start = 1'b0;
      if (k == 2) begin
        bus8.start = 1'b1;
        bus8.a = 8'hAA;
        bus8.b = 8'h55;
      end
      if (k == 3) bus8.start = 1'b0;
      if (bus8.done === 1'b1) ndone++;
      @(negedge clk);
    end
    n_vec++;
    chk("ign_done_pulses", 32'(ndone), 32'd1);
    chk("ign_diff", 32'(bus8.diff), 32'h0F);
    chk("ign_borrow", 32'(bus8.borrow), 32'h0);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = 8'h5A;
    bus8.b = 8'h3C;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    chk("arst_busy", 32'(bus8.busy), 32'h0);
    chk("arst_done", 32'(bus8.done), 32'h0);
    chk("arst_diff", 32'(bus8.diff), 32'h0);
    chk("arst_borrow", 32'(bus8.borrow), 32'h0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus8.done === 1'b1) ndone++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus8.done === 1'b1) ndone++;
    end
    chk("arst_no_done", 32'(ndone), 32'd0);
    run8(8'h03, 8'h05, lat, nbusy, pb, pd);
    n_vec++;
    chk("arst_after_diff", 32'(bus8.diff), 32'hFE);
    chk("arst_after_borrow", 32'(bus8.borrow), 32'h1);
    chk("arst_after_latency", 32'(lat), 32'd8);

    // W=1 instance
    run1(1'b0, 1'b1, lat);
    n_vec++;
    chk("w1_a_latency", 32'(lat), 32'd1);
    chk("w1_a_diff", 32'(bus1.diff), 32'h1);
    chk("w1_a_borrow", 32'(bus1.borrow), 32'h1);
`ifdef SERIAL_SUB_OVF_EN
    chk("w1_a_ovf", 32'(bus1.ovf), 32'h1);
`endif
    @(negedge clk);
    run1(1'b1, 1'b1, lat);
    n_vec++;
    chk("w1_b_latency", 32'(lat), 32'd1);
    chk("w1_b_diff", 32'(bus1.diff), 32'h0);
    chk("w1_b_borrow", 32'(bus1.borrow), 32'h0);
`ifdef SERIAL_SUB_OVF_EN
    chk("w1_b_ovf", 32'(bus1.ovf), 32'h0);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial W-bit subtractor computing A − B, LSB-first, one bit per clock. It is the subtract-direction counterpart of the team's adder cells. A single full-subtractor cell and a borrow flip-flop replace a W-bit ripple chain, giving an area-cheap datapath for control-path arithmetic. A start/busy/done handshake lets any controller or bench drive it.

Parameters:
W, 8, operand/result width in bits; legal W ≥ 1; bit-counter width is max(1, clog2(W)).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  W  minuend; captured on the accepting edge only
b  input  W  subtrahend; captured on the accepting edge only
busy  output  1  high in RUN and DONE
done  output  1  one-cycle result-valid pulse
diff  output  W  A − B mod 2^W; holds last result
borrow  output  1  final borrow-out (1 ⇔ unsigned A < B); holds last result

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow=0; shift registers, bit counter and borrow FF all 0. Reset asserted mid-RUN aborts immediately; no done is produced and the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE→RUN: on an edge with start=1.
  - Load sa←a, sb←b, borrow FF←0, count←0.
  - Call this edge 0.
- RUN: each edge 1..W processes one bit.
  - d = sa[0]^sb[0]^bff; bout = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bff).
  - sa and sb shift right; d shifts into the MSB of the result shift register; bff←bout; count++.
- RUN→DONE: at edge W, when count reaches W−1 before the increment.
  - On the same edge, diff←completed result and borrow←final bout.
- DONE: done=1 for exactly one cycle, between edges W and W+1. Then DONE→IDLE unconditionally.
- Latency: done is high W cycles after the accepting edge. The earliest next accept is edge W+2 (start held high is re-accepted then).
- start in RUN or DONE is ignored; a and b are not re-sampled.
- diff and borrow change only on the RUN→DONE edge. They are stable through DONE and IDLE, and also during the next RUN.
- W=1: a single RUN cycle; the counter is 1 bit.
- Arithmetic: results are modulo 2^W. Example: 0x00−0x01 = 0xFF with borrow=1.
- busy and done are registered-state decodes; no combinational path from start to any output.

Optional Feature:
SERIAL_SUB_OVF_EN
- Defined:
  - Adds output port ovf (1 bit, reset 0), the two's-complement signed overflow: ovf = (a[W−1]≠b[W−1]) && (diff[W−1]≠a[W−1]).
  - Computed from the sign bits captured at load and the final difference MSB.
  - Updated on the same edge as diff; holds like diff.
- Undefined: no ovf port, no sign-capture flops; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg:
  - state typedef (IDLE/RUN/DONE, 2-bit encoding)
  - default-width constant SUB_W_DEF=8
  - counter-width function max(1, clog2(W))
- One sub-module: full_subtractor, combinational (inputs x, y, bin; outputs d, bout). It is reusable by a future ripple subtractor and is instantiated once here.

Test Plan:
- W=8, a=0x5A, b=0x3C, start pulse → done high 8 cycles after the accepting edge; diff=0x1E, borrow=0, busy high for 9 cycles.
- a=0x00, b=0x01 → diff=0xFF, borrow=1; with SERIAL_SUB_OVF_EN, ovf=0.
- a=0xFF, b=0xFF, then a=0x80, b=0x01 back-to-back with start held high → first diff=0x00, borrow=0; second accepted at edge W+2, diff=0x7F, borrow=0, ovf=1 (macro on).
- start pulsed with a=0x10, b=0x01; at RUN cycle 3, drive start=1 with a=0xAA, b=0x55 → ignored; diff=0x0F, exactly one done pulse.
- rst_n low at RUN cycle 4 → all outputs 0 asynchronously; no done; after release, a=0x03, b=0x05 → diff=0xFE, borrow=1.
- W=1 build: a=0, b=1 → done 1 cycle after accept, diff=1, borrow=1; a=1, b=1 → diff=0, borrow=0.
